// File: rtl/mem_bus_responder.sv
// CPU memory-bus responder: decodes ROM / internal RAM / IO / unmapped space, posts writes, completes reads.
// Read latency ROM 2, RAM 1, unmapped 1, IO until io_ack or timeout; ready=0 only while a read is in flight.
module mem_bus_responder #(
  parameter int unsigned IO_TIMEOUT = 16
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic [15:0] i_addr,
  input  logic        i_rd_req,
  input  logic        i_wr_en,
  input  logic [7:0]  i_wr_data,
  output logic [7:0]  o_rd_data,
  output logic        o_ready,
  output logic [12:0] o_rom_addr,
  input  logic [7:0]  i_rom_q,
  output logic [7:0]  o_io_addr,
  output logic [7:0]  o_io_wdata,
  output logic        o_io_rd,
  output logic        o_io_wr,
  input  logic [7:0]  i_io_rdata,
  input  logic        i_io_ack,
  output logic        o_bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_ROM_WAIT, S_RAM_WAIT, S_IO_WAIT} state_t;

  localparam logic [7:0] LP_TIMEOUT = 8'(IO_TIMEOUT);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_rd_data, w_rd_data_nxt;
  logic        r_ready, w_ready_nxt;
  logic [12:0] r_rom_addr, w_rom_addr_nxt;
  logic [7:0]  r_io_addr, w_io_addr_nxt;
  logic [7:0]  r_io_wdata, w_io_wdata_nxt;
  logic        r_io_rd, w_io_rd_nxt;
  logic        r_io_wr, w_io_wr_nxt;
  logic        r_bus_err, w_bus_err_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        r_rom_phase, w_rom_phase_nxt;
  logic        r_unmapped, w_unmapped_nxt;
  logic [10:0] r_ram_raddr, w_ram_raddr_nxt;
  logic        w_ram_we;

  logic [7:0]  r_ram [2048];
  logic [7:0]  w_ram_q;

  logic w_is_rom, w_is_ram, w_is_io;

  assign w_is_rom = (i_addr[15:13] == 3'b000);
  assign w_is_ram = (i_addr[15:11] == 5'b00100);
  assign w_is_io  = (i_addr[15:8] == 8'h90);
  assign w_ram_q  = r_ram[r_ram_raddr];

  // RAM contents survive reset; only the control path is cleared.
  always_ff @(posedge sys_clk) begin
    if (w_ram_we) begin
      r_ram[i_addr[10:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_rd_data   <= 8'h00;
      r_ready     <= 1'b1;
      r_rom_addr  <= 13'd0;
      r_io_addr   <= 8'h00;
      r_io_wdata  <= 8'h00;
      r_io_rd     <= 1'b0;
      r_io_wr     <= 1'b0;
      r_bus_err   <= 1'b0;
      r_cnt       <= 8'd0;
      r_rom_phase <= 1'b0;
      r_unmapped  <= 1'b0;
      r_ram_raddr <= 11'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_rd_data   <= w_rd_data_nxt;
      r_ready     <= w_ready_nxt;
      r_rom_addr  <= w_rom_addr_nxt;
      r_io_addr   <= w_io_addr_nxt;
      r_io_wdata  <= w_io_wdata_nxt;
      r_io_rd     <= w_io_rd_nxt;
      r_io_wr     <= w_io_wr_nxt;
      r_bus_err   <= w_bus_err_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rom_phase <= w_rom_phase_nxt;
      r_unmapped  <= w_unmapped_nxt;
      r_ram_raddr <= w_ram_raddr_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_rd_data_nxt   = r_rd_data;
    w_ready_nxt     = r_ready;
    w_rom_addr_nxt  = r_rom_addr;
    w_io_addr_nxt   = r_io_addr;
    w_io_wdata_nxt  = r_io_wdata;
    w_io_rd_nxt     = r_io_rd;
    w_io_wr_nxt     = 1'b0;
    w_bus_err_nxt   = 1'b0;
    w_cnt_nxt       = r_cnt;
    w_rom_phase_nxt = r_rom_phase;
    w_unmapped_nxt  = r_unmapped;
    w_ram_raddr_nxt = r_ram_raddr;
    w_ram_we        = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (i_wr_en) begin
          // A write colliding with a read wins; the read is dropped and flagged.
          w_bus_err_nxt = i_rd_req;
          if (w_is_ram) begin
            w_ram_we = 1'b1;
          end else if (w_is_io) begin
            w_io_wr_nxt    = 1'b1;
            w_io_addr_nxt  = i_addr[7:0];
            w_io_wdata_nxt = i_wr_data;
          end
        end else if (i_rd_req) begin
          w_ready_nxt = 1'b0;
          if (w_is_rom) begin
            w_rom_addr_nxt  = i_addr[12:0];
            w_rom_phase_nxt = 1'b0;
            w_state_nxt     = S_ROM_WAIT;
          end else if (w_is_ram) begin
            w_ram_raddr_nxt = i_addr[10:0];
            w_unmapped_nxt  = 1'b0;
            w_state_nxt     = S_RAM_WAIT;
          end else if (w_is_io) begin
            w_io_addr_nxt = i_addr[7:0];
            w_io_rd_nxt   = 1'b1;
            w_cnt_nxt     = 8'd0;
            w_state_nxt   = S_IO_WAIT;
          end else begin
            w_unmapped_nxt = 1'b1;
            w_state_nxt    = S_RAM_WAIT;
          end
        end
      end
      S_ROM_WAIT: begin
        // First cycle lets the synchronous ROM present data for the registered address.
        if (!r_rom_phase) begin
          w_rom_phase_nxt = 1'b1;
        end else begin
          w_rd_data_nxt = i_rom_q;
          w_ready_nxt   = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end
      S_RAM_WAIT: begin
        w_rd_data_nxt = r_unmapped ? 8'hFF : w_ram_q;
        w_ready_nxt   = 1'b1;
        w_state_nxt   = S_IDLE;
      end
      S_IO_WAIT: begin
        if (i_io_ack) begin
          w_rd_data_nxt = i_io_rdata;
          w_io_rd_nxt   = 1'b0;
          w_ready_nxt   = 1'b1;
          w_state_nxt   = S_IDLE;
        end else if (r_cnt == LP_TIMEOUT) begin
          w_rd_data_nxt = 8'hFF;
          w_io_rd_nxt   = 1'b0;
          w_bus_err_nxt = 1'b1;
          w_ready_nxt   = 1'b1;
          w_state_nxt   = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ready_nxt = 1'b1;
      end
    endcase

    if ((r_state != S_IDLE) && (i_rd_req || i_wr_en)) begin
      w_bus_err_nxt = 1'b1;
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_ready    = r_ready;
  assign o_rom_addr = r_rom_addr;
  assign o_io_addr  = r_io_addr;
  assign o_io_wdata = r_io_wdata;
  assign o_io_rd    = r_io_rd;
  assign o_io_wr    = r_io_wr;
  assign o_bus_err  = r_bus_err;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: directed vector table, hand-written corner sequences,
// then random traffic checked against an address-map level reference model.
module tb_mem_bus_responder;

  localparam int TO = 16;

  logic        sys_clk = 1'b0;
  logic        reset_n;
  logic [15:0] i_addr;
  logic        i_rd_req, i_wr_en;
  logic [7:0]  i_wr_data;
  logic [7:0]  o_rd_data;
  logic        o_ready;
  logic [12:0] o_rom_addr;
  logic [7:0]  i_rom_q;
  logic [7:0]  o_io_addr, o_io_wdata;
  logic        o_io_rd, o_io_wr;
  logic [7:0]  i_io_rdata;
  logic        i_io_ack;
  logic        o_bus_err;

  int n_checks = 0;
  int n_err    = 0;
  logic [7:0] mem_m [2048];

  mem_bus_responder #(.IO_TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .i_addr(i_addr), .i_rd_req(i_rd_req),
    .i_wr_en(i_wr_en), .i_wr_data(i_wr_data), .o_rd_data(o_rd_data), .o_ready(o_ready),
    .o_rom_addr(o_rom_addr), .i_rom_q(i_rom_q), .o_io_addr(o_io_addr),
    .o_io_wdata(o_io_wdata), .o_io_rd(o_io_rd), .o_io_wr(o_io_wr),
    .i_io_rdata(i_io_rdata), .i_io_ack(i_io_ack), .o_bus_err(o_bus_err)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [7:0] rom_fn(input logic [12:0] a);
    return a[7:0] ^ {3'b000, a[12:8]} ^ 8'h78;
  endfunction

  // Synchronous ROM: data one clock after the address.
  always @(posedge sys_clk) i_rom_q <= rom_fn(o_rom_addr);

  // 0 = ROM, 1 = RAM, 2 = IO, 3 = unmapped
  function automatic int region(input logic [15:0] a);
    if (a < 16'h2000) return 0;
    if (a < 16'h2800) return 1;
    if (a >= 16'h9000 && a < 16'h9100) return 2;
    return 3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] wd);
    @(negedge sys_clk);
    i_addr = a; i_wr_en = 1'b1; i_wr_data = wd;
    @(negedge sys_clk);
    i_wr_en = 1'b0;
    check("wr_ready", 32'(o_ready), 32'd1);
    check("wr_bus_err", 32'(o_bus_err), 32'd0);
    if (region(a) == 2) begin
      check("io_wr_pulse", 32'(o_io_wr), 32'd1);
      check("io_wr_addr", 32'(o_io_addr), 32'(a[7:0]));
      check("io_wr_data", 32'(o_io_wdata), 32'(wd));
    end else begin
      check("io_wr_quiet", 32'(o_io_wr), 32'd0);
    end
    if (region(a) == 1) mem_m[a - 16'h2000] = wd;
  endtask

  // Issues a read; io_ack is offered for one cycle once ack_dly wait cycles have been seen.
  task automatic do_read(input logic [15:0] a, input int ack_dly, input logic [7:0] iod,
                         output logic [7:0] d, output int lows, output int errs,
                         output int rds, output logic [7:0] ioa);
    @(negedge sys_clk);
    i_addr = a; i_rd_req = 1'b1;
    @(negedge sys_clk);
    i_rd_req = 1'b0;
    ioa = o_io_addr;
    lows = 0; errs = 0; rds = 0;
    while (!o_ready && lows < 100) begin
      lows++;
      errs += int'(o_bus_err);
      rds  += int'(o_io_rd);
      if (lows == ack_dly) begin
        i_io_ack = 1'b1; i_io_rdata = iod;
      end else begin
        i_io_ack = 1'b0;
      end
      @(negedge sys_clk);
    end
    i_io_ack = 1'b0;
    if (lows >= 100) begin
      n_checks++; n_err++;
      $display("FAIL read_hang: ready still 0 after %0d cycles, required 1", lows);
    end
    errs += int'(o_bus_err);
    d = o_rd_data;
  endtask

  task automatic model_read(input logic [15:0] a, input int ack_dly, input logic [7:0] iod,
                            output logic [7:0] d, output int lows, output int errs);
    errs = 0;
    case (region(a))
      0: begin d = rom_fn(a[12:0]); lows = 2; end
      1: begin d = mem_m[a - 16'h2000]; lows = 1; end
      2: begin
        if (ack_dly >= 1 && ack_dly <= TO + 1) begin d = iod; lows = ack_dly; end
        else begin d = 8'hFF; lows = TO + 1; errs = 1; end
      end
      default: begin d = 8'hFF; lows = 1; end
    endcase
  endtask

  typedef struct {
    logic [15:0] addr;
    bit          wr;
    logic [7:0]  wdata;
    int          ack_dly;
    logic [7:0]  iod;
    logic [7:0]  exp_d;
    int          exp_lows;
    int          exp_err;
  } vec_t;

  vec_t vecs [17];

  initial begin : main
    logic [7:0] d, ioa, ed;
    int lows, errs, rds, el, ee;

    vecs[0]  = '{16'h2010, 1'b1, 8'hC3, 0,      8'h00, 8'h00, 0,      0};
    vecs[1]  = '{16'h2010, 1'b0, 8'h00, 0,      8'h00, 8'hC3, 1,      0};
    vecs[2]  = '{16'h0123, 1'b0, 8'h00, 0,      8'h00, 8'h5A, 2,      0};
    vecs[3]  = '{16'h9004, 1'b0, 8'h00, 3,      8'h77, 8'h77, 3,      0};
    vecs[4]  = '{16'h9004, 1'b0, 8'h00, 0,      8'h00, 8'hFF, TO + 1, 1};
    vecs[5]  = '{16'hF000, 1'b0, 8'h00, 0,      8'h00, 8'hFF, 1,      0};
    vecs[6]  = '{16'h27FF, 1'b1, 8'hA5, 0,      8'h00, 8'h00, 0,      0};
    vecs[7]  = '{16'h27FF, 1'b0, 8'h00, 0,      8'h00, 8'hA5, 1,      0};
    vecs[8]  = '{16'h1FFF, 1'b0, 8'h00, 0,      8'h00, 8'h98, 2,      0};
    vecs[9]  = '{16'h2800, 1'b0, 8'h00, 0,      8'h00, 8'hFF, 1,      0};
    vecs[10] = '{16'h90FF, 1'b0, 8'h00, TO + 1, 8'h3C, 8'h3C, TO + 1, 0};
    vecs[11] = '{16'h90FF, 1'b0, 8'h00, TO + 2, 8'h3C, 8'hFF, TO + 1, 1};
    vecs[12] = '{16'h8FFF, 1'b0, 8'h00, 0,      8'h00, 8'hFF, 1,      0};
    vecs[13] = '{16'h0005, 1'b1, 8'h99, 0,      8'h00, 8'h00, 0,      0};
    vecs[14] = '{16'h0005, 1'b0, 8'h00, 0,      8'h00, 8'h7D, 2,      0};
    vecs[15] = '{16'h9033, 1'b1, 8'h44, 0,      8'h00, 8'h00, 0,      0};
    vecs[16] = '{16'h9100, 1'b0, 8'h00, 0,      8'h00, 8'hFF, 1,      0};

    reset_n = 1'b0; i_addr = 16'h0; i_rd_req = 1'b0; i_wr_en = 1'b0;
    i_wr_data = 8'h0; i_io_rdata = 8'h0; i_io_ack = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_rd_data", 32'(o_rd_data), 32'd0);
    check("rst_io_rd", 32'(o_io_rd), 32'd0);
    check("rst_io_wr", 32'(o_io_wr), 32'd0);
    check("rst_bus_err", 32'(o_bus_err), 32'd0);
    check("rst_rom_addr", 32'(o_rom_addr), 32'd0);
    check("rst_io_addr", 32'(o_io_addr), 32'd0);
    check("rst_io_wdata", 32'(o_io_wdata), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].wdata);
      end else begin
        do_read(vecs[i].addr, vecs[i].ack_dly, vecs[i].iod, d, lows, errs, rds, ioa);
        check($sformatf("vec%0d_data", i), 32'(d), 32'(vecs[i].exp_d));
        check($sformatf("vec%0d_ready_low", i), 32'(lows), 32'(vecs[i].exp_lows));
        check($sformatf("vec%0d_bus_err", i), 32'(errs), 32'(vecs[i].exp_err));
        if (region(vecs[i].addr) == 2) begin
          check($sformatf("vec%0d_io_addr", i), 32'(ioa), 32'(vecs[i].addr[7:0]));
          check($sformatf("vec%0d_io_rd_cycles", i), 32'(rds), 32'(vecs[i].exp_lows));
        end
      end
    end

    // Simultaneous read and write: write wins, single error pulse, ready never drops.
    @(negedge sys_clk);
    i_addr = 16'h2000; i_rd_req = 1'b1; i_wr_en = 1'b1; i_wr_data = 8'h11;
    @(negedge sys_clk);
    i_rd_req = 1'b0; i_wr_en = 1'b0;
    mem_m[0] = 8'h11;
    check("collide_ready", 32'(o_ready), 32'd1);
    check("collide_bus_err", 32'(o_bus_err), 32'd1);
    @(negedge sys_clk);
    check("collide_err_single", 32'(o_bus_err), 32'd0);
    check("collide_ready2", 32'(o_ready), 32'd1);
    do_read(16'h2000, 0, 8'h00, d, lows, errs, rds, ioa);
    check("collide_ram0", 32'(d), 32'h11);

    // Request during an in-flight ROM read: flagged, read unaffected.
    @(negedge sys_clk);
    i_addr = 16'h0123; i_rd_req = 1'b1;
    @(negedge sys_clk);
    check("busy_ready0", 32'(o_ready), 32'd0);
    @(negedge sys_clk);
    i_rd_req = 1'b0;
    check("busy_bus_err", 32'(o_bus_err), 32'd1);
    check("busy_ready1", 32'(o_ready), 32'd0);
    @(negedge sys_clk);
    check("busy_done_ready", 32'(o_ready), 32'd1);
    check("busy_done_data", 32'(o_rd_data), 32'h5A);
    check("busy_done_err", 32'(o_bus_err), 32'd0);

    // io_ack while idle is ignored.
    @(negedge sys_clk);
    i_io_ack = 1'b1; i_io_rdata = 8'hAB;
    @(negedge sys_clk);
    i_io_ack = 1'b0;
    check("idle_ack_ready", 32'(o_ready), 32'd1);
    check("idle_ack_data", 32'(o_rd_data), 32'h5A);
    check("idle_ack_err", 32'(o_bus_err), 32'd0);

    // Reset while waiting on IO aborts silently; RAM keeps its contents.
    @(negedge sys_clk);
    i_addr = 16'h9004; i_rd_req = 1'b1;
    @(negedge sys_clk);
    i_rd_req = 1'b0;
    check("rstio_io_rd", 32'(o_io_rd), 32'd1);
    @(negedge sys_clk);
    reset_n = 1'b0;
    @(negedge sys_clk);
    reset_n = 1'b1;
    check("rstio_ready", 32'(o_ready), 32'd1);
    check("rstio_io_rd0", 32'(o_io_rd), 32'd0);
    check("rstio_rd_data", 32'(o_rd_data), 32'd0);
    check("rstio_err", 32'(o_bus_err), 32'd0);
    @(negedge sys_clk);
    check("rstio_err_after", 32'(o_bus_err), 32'd0);
    do_read(16'h0123, 0, 8'h00, d, lows, errs, rds, ioa);
    check("rstio_rom_data", 32'(d), 32'h5A);
    check("rstio_rom_lows", 32'(lows), 32'd2);
    do_read(16'h2010, 0, 8'h00, d, lows, errs, rds, ioa);
    check("rstio_ram_kept", 32'(d), 32'hC3);

    // Random traffic against the reference model.
    for (int i = 0; i < 32; i++) do_write(16'h2000 + 16'(i), 8'($urandom));
    for (int n = 0; n < 150; n++) begin
      logic [15:0] a;
      int r, ack;
      logic [7:0] iod;
      r = int'($urandom_range(0, 3));
      case (r)
        0: a = 16'($urandom_range(0, 16'h1FFF));
        1: a = 16'h2000 + 16'($urandom_range(0, 31));
        2: a = 16'h9000 + 16'($urandom_range(0, 255));
        default: a = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(16'h2800, 16'h8FFF))
                                                 : 16'($urandom_range(16'h9100, 16'hFFFF));
      endcase
      if ($urandom_range(0, 3) == 0 && r != 0) begin
        do_write(a, 8'($urandom));
      end else begin
        ack = int'($urandom_range(1, TO + 3));
        iod = 8'($urandom);
        model_read(a, ack, iod, ed, el, ee);
        do_read(a, ack, iod, d, lows, errs, rds, ioa);
        check($sformatf("rnd%0d_data@%h", n, a), 32'(d), 32'(ed));
        check($sformatf("rnd%0d_lows@%h", n, a), 32'(lows), 32'(el));
        check($sformatf("rnd%0d_err@%h", n, a), 32'(errs), 32'(ee));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 Parameter IO_TIMEOUT, default 16, max cycles io_rd waits for io_ack before abort (range 2..255).
REQ-002 sys_clk  in  1  system clock; all logic on rising edge.
REQ-003 reset_n  in  1  synchronous, active-low reset.
REQ-004 addr  in  16  CPU address, stable from rd_req/wr_en until ready=1.
REQ-005 rd_req  in  1  one-cycle read request pulse from CPU.
REQ-006 wr_en  in  1  one-cycle write strobe from CPU.
REQ-007 wr_data  in  8  CPU write data, valid with wr_en.
REQ-008 rd_data  out  8  read data, valid when ready rises; held until next read completes.
REQ-009 ready  out  1  1 = idle or transfer complete; 0 = read in progress.
REQ-010 rom_addr  out  13  registered ROM address; rom_q  in  8  ROM data, one cycle after rom_addr.
REQ-011 io_addr  out  8; io_wdata  out  8; io_rd  out  1; io_wr  out  1; io_rdata  in  8; io_ack  in  1  peripheral port.
REQ-012 bus_err  out  1  one-cycle pulse on protocol violation or IO timeout.

Function
REQ-013 Address map: 0x0000-0x1FFF ROM; 0x2000-0x27FF internal 2 KB RAM; 0x9000-0x90FF IO (io_addr = addr[7:0]); all else unmapped.
REQ-014 States IDLE, ROM_WAIT, RAM_WAIT, IO_WAIT; only IDLE accepts requests; ready=1 exactly in IDLE.
REQ-015 rd_req sampled in IDLE at edge T: addr decoded, ready<=0, rom_addr/RAM read address/io_addr registered at edge T.
REQ-016 ROM read: edge T -> ROM_WAIT; edge T+2 rd_data<=rom_q, ready<=1, -> IDLE (ready low 2 cycles).
REQ-017 RAM read: edge T -> RAM_WAIT; edge T+1 rd_data<=RAM word, ready<=1, -> IDLE (ready low 1 cycle).
REQ-018 Unmapped read: edge T+1 rd_data<=0xFF, ready<=1; no bus_err.
REQ-019 IO read: edge T io_rd<=1 -> IO_WAIT; io_rd held high until completion; first edge sampling io_ack=1: rd_data<=io_rdata, io_rd<=0, ready<=1, -> IDLE.
REQ-020 IO timeout: 8-bit counter cleared at entry to IO_WAIT, incremented per IO_WAIT cycle; when it reaches IO_TIMEOUT with no io_ack: rd_data<=0xFF, io_rd<=0, bus_err pulse, ready<=1, -> IDLE; io_ack on that same edge wins (normal completion).
REQ-021 Writes posted: wr_en in IDLE never drops ready; RAM written at the wr_en edge; ROM and unmapped writes silently dropped.
REQ-022 IO write: io_wr pulses one cycle, io_addr/io_wdata registered from addr[7:0]/wr_data on the same edge; io_ack ignored for writes.
REQ-023 rd_req and wr_en in same IDLE cycle: write performed, read dropped, bus_err pulse, ready stays 1.
REQ-024 rd_req or wr_en outside IDLE: ignored, bus_err pulse, in-flight read unaffected.
REQ-025 Read-after-write to same RAM address in consecutive cycles returns new data.
REQ-026 io_ack while in IDLE or during an IO write: ignored.

Reset
REQ-027 reset_n=0 at an edge: state IDLE, ready=1, rd_data=0x00, io_rd=0, io_wr=0, bus_err=0, rom_addr=0, io_addr=0, io_wdata=0, timeout counter 0.
REQ-028 Reset mid-read aborts the transfer with no completion, no bus_err; RAM contents not reset.

Verification
REQ-029 rd_req addr 0x0123, rom_q=0x5A at cycle after rom_addr=0x0123 -> ready low 2 cycles, rd_data=0x5A on ready rise.
REQ-030 wr_en addr 0x2010 data 0xC3, next cycle rd_req 0x2010 -> ready stays 1 during write, then low 1 cycle, rd_data=0xC3.
REQ-031 rd_req 0x9004, io_ack=1 with io_rdata=0x77 three cycles later -> io_addr=0x04, io_rd high 3 cycles, rd_data=0x77, no bus_err.
REQ-032 rd_req 0x9004, io_ack never -> ready low IO_TIMEOUT cycles (+1 for entry), rd_data=0xFF, single bus_err pulse.
REQ-033 rd_req and wr_en together to 0x2000 data 0x11 -> RAM[0]=0x11, ready stays 1, bus_err pulse; rd_req 0xF000 -> rd_data=0xFF after 1 cycle.
REQ-034 reset_n=0 one cycle while in IO_WAIT -> ready=1, io_rd=0, rd_data=0x00 next cycle; next ROM read completes normally.
